// File: rtl/arb_pkg.sv
// Shared arbitration definitions for the memory request queue.
// State encoding and tag-width helper, reused by the pop-side demux.
package arb_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    function automatic int clog2(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: rotate by ptr, priority-encode, un-rotate.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int TAGW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [TAGW-1:0] ptr,
    output logic            valid,
    output logic [TAGW-1:0] idx
);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [TAGW-1:0]   w_off;

    assign w_dbl = {req, req};
    assign w_rot = w_dbl[ptr +: NREQ];

    always_comb begin
        w_off = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = TAGW'(j);
            end
        end
    end

    assign valid = |req;
    assign idx   = ptr + w_off;

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin push-side arbiter for the shared memory request fifo,
// with burst locking capped at MAXBURST beats.
module mem_req_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int TAGW     = clog2(NREQ),
    parameter int WIDTH    = 16,
    parameter int MAXBURST = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       gnt,
    output logic                  q_push,
    output logic [TAGW+WIDTH-1:0] q_data,
    input  logic                  q_full,
    input  logic                  flush,
    output logic                  locked,
    output logic                  burst_err
);

    logic [0:0]      r_st;
    logic [TAGW-1:0] r_ptr;
    logic [TAGW-1:0] r_owner;
    logic [7:0]      r_beats;
    logic            r_burst_err;

    logic             w_pick_valid;
    logic [TAGW-1:0]  w_pick_idx;
    logic             w_locked;
    logic [TAGW-1:0]  w_cand;
    logic             w_cand_valid;
    logic             w_can_accept;
    logic             w_accept;
    logic             w_force;
    logic             w_eff_last;
    logic [WIDTH-1:0] w_data;

    rr_pick #(
        .NREQ(NREQ),
        .TAGW(TAGW)
    ) u_pick (
        .req  (req),
        .ptr  (r_ptr),
        .valid(w_pick_valid),
        .idx  (w_pick_idx)
    );

    assign w_locked     = (r_st == ST_LOCKED);
    assign w_cand       = w_locked ? r_owner : w_pick_idx;
    assign w_cand_valid = w_locked ? req[r_owner] : w_pick_valid;
    assign w_can_accept = !q_full && !flush && !reset;
    assign w_accept     = w_can_accept && w_cand_valid;

    // beats counts accepted beats of the current burst; the
    // MAXBURST-th beat is always treated as the last one
    assign w_force    = (r_beats == 8'(MAXBURST - 1));
    assign w_eff_last = req_last[w_cand] || w_force;

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_cand == TAGW'(i)) begin
                w_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = w_accept && (w_cand == TAGW'(i));
        end
    end

    assign q_push    = w_accept;
    assign q_data    = {w_cand, w_data};
    assign locked    = w_locked;
    assign burst_err = r_burst_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st        <= ST_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_beats     <= '0;
            r_burst_err <= 1'b0;
        end else if (flush) begin
            r_st    <= ST_IDLE;
            r_beats <= '0;
        end else if (w_accept) begin
            if (w_eff_last) begin
                r_st    <= ST_IDLE;
                r_ptr   <= w_cand + TAGW'(1);
                r_beats <= '0;
                if (w_force && !req_last[w_cand]) begin
                    r_burst_err <= 1'b1;
                end
            end else if (!w_locked) begin
                r_st    <= ST_LOCKED;
                r_owner <= w_cand;
                r_beats <= 8'd1;
            end else begin
                r_beats <= r_beats + 8'd1;
            end
        end
    end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Round-robin arbiter that shares one `fifo` instance (the memory request queue) among `NREQ` requesters. Each cycle it grants at most one requester, tags the accepted entry with the requester index and drives the fifo push port. It supports multi-beat bursts that lock the queue to one owner until the last beat. The arbiter sits between the load/store and fetch request sources and the queue's push side; the pop side is untouched.

## Interface
- `NREQ`, 4: number of requesters, power of two, 2..8
- `TAGW`, 2: log2(`NREQ`), width of the requester tag
- `WIDTH`, 16: payload bits per beat
- `MAXBURST`, 8: maximum beats per locked burst, 1..255

- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  NREQ  requester i has a valid beat
- `req_data`  in  NREQ*WIDTH  beat of requester i at bits [i*WIDTH +: WIDTH]
- `req_last`  in  NREQ  beat of requester i ends its burst
- `gnt`  out  NREQ  one-hot or zero; beat of requester i accepted at this edge
- `q_push`  out  1  to fifo `push`
- `q_data`  out  TAGW+WIDTH  to fifo `data_in`, {tag, payload}
- `q_full`  in  1  from fifo `q_full`
- `flush`  in  1  also wired to fifo `flush`; aborts arbitration
- `locked`  out  1  a burst owner holds the queue
- `burst_err`  out  1  sticky: a burst was force-terminated at `MAXBURST`

## Operation
- Registered state: `st` {IDLE, LOCKED}, `ptr` [TAGW-1:0] (highest-priority index), `owner` [TAGW-1:0], `beats` [7:0], `burst_err`.
- `can_accept = !q_full && !flush && !reset`.
- In IDLE, the candidate is the first i with `req[i]`, scanning from `ptr` upward and wrapping modulo `NREQ`.
- In LOCKED, the candidate is `owner` only, and only when `req[owner]`. Other requesters get no grant. If the owner idles, a bubble occurs and the state stays LOCKED.
- `gnt[cand] = can_accept && candidate exists`.
- `q_push = |gnt`.
- `q_data = {cand, req_data[cand]}` whenever `q_push`; otherwise don't-care.
- The grant path is combinational. A beat counts as accepted only at an edge where `gnt` is high. The requester holds `req`, `req_data` and `req_last` stable until granted.
- Effective last beat: `eff_last = req_last[cand] || (beats == MAXBURST-1)`.
- On an accepted beat in IDLE:
  - if `eff_last`: stay IDLE, `ptr <= cand+1`.
  - else: go LOCKED, `owner <= cand`, `beats <= 1`.
- On an accepted beat in LOCKED:
  - if `eff_last`: go IDLE, `ptr <= owner+1`, `beats <= 0`.
  - else: `beats <= beats+1`.
- Forced release (`beats == MAXBURST-1` with `!req_last`) sets `burst_err`. `burst_err` clears only on reset.
- `flush`: no grant that cycle. Next state is IDLE, `beats <= 0`, and `ptr` is unchanged. A burst in progress is abandoned, matching the fifo discarding its contents.
- `q_full` while LOCKED: stall. The state is held and no grant is given.
- `locked = (st == LOCKED)`.
- All index arithmetic wraps modulo `NREQ` (TAGW-bit truncation).

## Timing
- Reset values: `st`=IDLE, `ptr`=0, `owner`=0, `beats`=0, `burst_err`=0. While `reset` is high, `gnt`=0, `q_push`=0 and `locked`=0.
- Reset asserted mid-burst returns to IDLE immediately (asynchronously). A beat presented on that edge is not accepted.
- Latency: 0 cycles. The beat is written into the fifo at the same edge that `gnt` is high. The fifo `q_full` is registered-derived, so no combinational loop exists.
- Throughput: 1 beat/cycle when not full.
- Fairness: after a burst from i completes, i is lowest priority. A single requester always winning back-to-back is allowed only when no other `req` is set.
- Simultaneous `flush` and `q_full`: `flush` dominates; the next state is IDLE.

## Structure
- Shared package `arb_pkg`: the state encoding localparams (IDLE=0, LOCKED=1) and the tag-width constant helper (clog2), reused by future pop-side demux.
- Sub-module `rr_pick`: combinational, with inputs `req` [NREQ] and `ptr` [TAGW]; outputs `valid` and `idx` [TAGW]. Implement by rotate, priority-encode, un-rotate.
- Top-level: FSM and counters plus `rr_pick`. Target under 250 lines.

## Test plan
- Reset then `req=4'b1111`, all `req_last=1`, `q_full=0` → `gnt` sequence 0001, 0010, 0100, 1000, 0001; `q_data` tags 0,1,2,3,0.
- Requester 2 bursts 3 beats (`req_last` on beat 3) while `req=4'b1111` → `gnt=0100` for 3 consecutive cycles, `locked`=1 for 2 cycles, then `gnt=1000`.
- `q_full=1` for 2 cycles mid-burst of requester 1 → `gnt=0`, `q_push=0`, `locked` stays 1; the burst resumes with owner 1 once `q_full=0`.
- Requester 0 holds `req_last=0` for 10 beats, `MAXBURST=8` → release after beat 8, `burst_err`=1, next grant goes to requester 1 if requesting.
- `flush` pulsed while LOCKED by owner 3 with `ptr`=3 → no grant that cycle; `locked`=0 next cycle; `ptr` is still 3, so requester 3 wins the next tie.
- `reset` asserted asynchronously mid-burst → `gnt`, `q_push`, `locked` and `burst_err` go 0 without a clock edge; `ptr`=0 after release.
